// File: rtl/slon5_scan_m.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// slon5_scan_m
//
// Time-multiplexed scanner for a multi-digit LED display. The scan visits
// digits 0..DIGITS-1 in order. Each digit slot is BLANK_CYCLES of all-off,
// which suppresses ghosting, followed by DWELL_CYCLES with that digit lit.
//
// New frames arrive over a valid/ready handshake into a single pending
// register. That register is copied to the displayed ("active") frame only
// at a frame boundary, so the display never shows half of one frame and
// half of another.
//
// Optional feature: when the macro SLON5_SCAN_BRIGHT_EN is defined, the
// design gains a 4-bit 'bright' input. It shortens the part of each ON
// period during which segments are driven. The default build leaves the
// macro undefined and drives the segments for the whole ON period.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous, active-low reset
//   seg_in       frame to load; digit k is seg_in[k*SEG_W +: SEG_W]
//   in_valid     seg_in holds a frame to load
//   in_ready     scanner can accept a frame (pending register empty)
//   bright       (SLON5_SCAN_BRIGHT_EN only) brightness 0..15,
//                sampled at frame_start
//   seg_out      active-high segment drive for the selected digit
//   dig_sel      active-high one-hot digit select, zero while blanking
//   frame_start  one-cycle pulse on the first cycle of every frame
// ---------------------------------------------------------------------------
module slon5_scan_m #(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 8,
  parameter int DWELL_CYCLES = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGITS*SEG_W-1:0] seg_in,
  input  logic                    in_valid,
`ifdef SLON5_SCAN_BRIGHT_EN
  input  logic [3:0]              bright,
`endif
  output logic                    in_ready,
  output logic [SEG_W-1:0]        seg_out,
  output logic [DIGITS-1:0]       dig_sel,
  output logic                    frame_start
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic [DIGITS*SEG_W-1:0] active_q, active_d;
  logic [DIGITS*SEG_W-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    in_ready_q, in_ready_d;
  logic [SEG_W-1:0]        seg_out_q, seg_out_d;
  logic [DIGITS-1:0]       dig_sel_q, dig_sel_d;
  logic                    frame_start_q, frame_start_d;

  logic                    transfer;
  logic                    boundary;
  logic                    lit;
  logic [SEG_W-1:0]        seg_sel;

`ifdef SLON5_SCAN_BRIGHT_EN
  logic [3:0]              bright_q, bright_d;
  logic [31:0]             lit_lim;
`endif

  // run_q is clear only for the first edge after reset release. That edge
  // enters cycle 0 of the first BLANK slot without advancing the counters,
  // so frame_start and in_ready both appear on the first cycle.
  //
  // Registered outputs are computed from the *next* state, which keeps
  // dig_sel and seg_out aligned with the slot they belong to.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    run_d         = 1'b1;
    active_d      = active_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    frame_start_d = 1'b0;
    seg_sel       = '0;
    lit           = 1'b1;

    transfer = in_valid & in_ready_q;
    boundary = run_q && (state_q == ST_ON) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);

    if (!run_q) begin
      state_d       = ST_BLANK;
      idx_d         = '0;
      cnt_d         = '0;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
      frame_start_d = boundary;
    end

    // The active frame changes only at a frame boundary. With nothing
    // pending, a transfer on the boundary edge goes straight to active, so
    // the pending register never fills and in_ready stays high.
    if (boundary) begin
      if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end else if (transfer) begin
        active_d = seg_in;
      end
    end else if (transfer) begin
      pend_d     = seg_in;
      pend_vld_d = 1'b1;
    end

    in_ready_d = ~pend_vld_d;

`ifdef SLON5_SCAN_BRIGHT_EN
    // bright is taken during the frame_start cycle and also forwarded
    // combinationally on that cycle. This covers a first ON slot that
    // begins right after a one-cycle blank.
    bright_d = frame_start_q ? bright : bright_q;
    lit_lim  = (32'(DWELL_CYCLES) * (32'(bright_d) + 32'd1)) >> 4;
    lit      = (32'(cnt_d) < lit_lim);
`endif

    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        seg_sel = active_d[k*SEG_W +: SEG_W];
      end
    end

    if (state_d == ST_ON) begin
      dig_sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_out_d = lit ? seg_sel : '0;
    end else begin
      dig_sel_d = '0;
      seg_out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      run_q         <= 1'b0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      seg_out_q     <= '0;
      dig_sel_q     <= '0;
      frame_start_q <= 1'b0;
`ifdef SLON5_SCAN_BRIGHT_EN
      bright_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      run_q         <= run_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      in_ready_q    <= in_ready_d;
      seg_out_q     <= seg_out_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
`ifdef SLON5_SCAN_BRIGHT_EN
      bright_q      <= bright_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign seg_out     = seg_out_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_slon5_scan_m.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_slon5_scan_m
//
// Testbench for slon5_scan_m with DIGITS=4, SEG_W=8, DWELL_CYCLES=8 and
// BLANK_CYCLES=2. Each frame is therefore 40 cycles long, and each slot is
// 10 cycles: 2 blank cycles followed by 8 ON cycles.
//
// A time-based reference model predicts the expected outputs on every
// cycle. Frame loads come from a table. Each accepted load pushes the digit
// values it should produce onto a scoreboard queue. That entry is popped and
// compared when the DUT has displayed a full new frame.
// ---------------------------------------------------------------------------
module tb_slon5_scan_m;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 8;
  localparam int DWELL  = 8;
  localparam int BLANK  = 2;
  localparam int SLOT   = DWELL + BLANK;
  localparam int FRAME  = DIGITS * SLOT;

  logic                    clk      = 1'b0;
  logic                    rst      = 1'b0;
  logic [DIGITS*SEG_W-1:0] seg_in   = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [SEG_W-1:0]        seg_out;
  logic [DIGITS-1:0]       dig_sel;
  logic                    frame_start;
`ifdef SLON5_SCAN_BRIGHT_EN
  logic [3:0]              bright = 4'hF;
`endif

  slon5_scan_m #(
    .DIGITS       (DIGITS),
    .SEG_W        (SEG_W),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .in_valid    (in_valid),
`ifdef SLON5_SCAN_BRIGHT_EN
    .bright      (bright),
`endif
    .in_ready    (in_ready),
    .seg_out     (seg_out),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
  } frame_exp_t;

  typedef struct {
    logic [31:0] frame;
    int          drive_pos;
    bit          accept;
    bit          ready_after;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [7:0]  d3;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = -1;
  logic [31:0] m_active = '0;
  logic [31:0] m_pend   = '0;
  bit         m_pv      = 1'b0;
  bit         m_ready   = 1'b0;
  bit         frame_check = 1'b0;
  logic [7:0] shown [DIGITS];
  frame_exp_t exp_q [$];
  vec_t       vecs [5];

  // Compare one value and report the result; every comparison goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive the handshake inputs; called just after a falling edge.
  task automatic applyStimulus(input logic [31:0] frame, input logic valid);
    seg_in   = frame;
    in_valid = valid;
  endtask

  // Advance one clock cycle. The reference model updates on the rising
  // edge, and the DUT outputs are checked on the following falling edge.
  task automatic step();
    bit         boundary;
    bit         transfer;
    bit         changed;
    int         pos;
    int         slot;
    int         sub;
    logic [3:0] e_dig;
    logic [7:0] e_seg;
    frame_exp_t e;

    @(posedge clk);
    boundary = (cyc >= 0) && ((cyc % FRAME) == FRAME - 1);
    transfer = in_valid && m_ready;
    changed  = 1'b0;
    if (boundary) begin
      if (m_pv) begin
        m_active = m_pend;
        m_pv     = 1'b0;
        changed  = 1'b1;
      end else if (transfer) begin
        m_active = seg_in;
        changed  = 1'b1;
      end
    end else if (transfer) begin
      m_pend = seg_in;
      m_pv   = 1'b1;
    end
    m_ready = !m_pv;
    cyc++;
    if (changed) frame_check = 1'b1;

    @(negedge clk);
    pos  = cyc % FRAME;
    slot = pos / SLOT;
    sub  = pos % SLOT;
    if (sub >= BLANK) begin
      e_dig = 4'b0001 << slot;
      e_seg = m_active[slot*8 +: 8];
    end else begin
      e_dig = 4'b0000;
      e_seg = 8'h00;
    end
    checkOutput("dig_sel", 32'(dig_sel), 32'(e_dig));
    checkOutput("seg_out", 32'(seg_out), 32'(e_seg));
    checkOutput("frame_start", 32'(frame_start), 32'(pos == 0));
    checkOutput("in_ready", 32'(in_ready), 32'(m_ready));

    if (sub == 5) shown[slot] = seg_out;

    if (pos == FRAME - 1 && frame_check) begin
      frame_check = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: actual=new frame shown required=no change (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_d0", 32'(shown[0]), 32'(e.d0));
        checkOutput("frame_d1", 32'(shown[1]), 32'(e.d1));
        checkOutput("frame_d2", 32'(shown[2]), 32'(e.d2));
        checkOutput("frame_d3", 32'(shown[3]), 32'(e.d3));
      end
    end
  endtask

  // Step until the frame position matches, optionally also waiting for the
  // scoreboard to drain. The number of steps is bounded.
  task automatic waitPos(input int pos, input bit need_empty);
    int budget;
    budget = 200;
    while (!(((cyc % FRAME) == pos) && (!need_empty || exp_q.size() == 0))) begin
      if (budget == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL wait_pos: actual=timeout required=pos %0d (cycle %0d)", pos, cyc);
        return;
      end
      budget--;
      step();
    end
  endtask

  task automatic resetModel();
    m_active    = '0;
    m_pend      = '0;
    m_pv        = 1'b0;
    m_ready     = 1'b0;
    frame_check = 1'b0;
    cyc         = -1;
    for (int k = 0; k < DIGITS; k++) shown[k] = 8'h00;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // frame, drive position, accepted, in_ready next cycle, expected digits 0..3
    vecs[0] = '{32'h3F06_5B4F,  5, 1'b1, 1'b0, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    vecs[1] = '{32'h1234_5678, 39, 1'b1, 1'b1, 8'h78, 8'h56, 8'h34, 8'h12};
    vecs[2] = '{32'hA1B2_C3D4, 10, 1'b1, 1'b0, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    vecs[3] = '{32'hDEAD_BEEF, 20, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{32'h00FF_8001, 38, 1'b1, 1'b0, 8'h01, 8'h80, 8'hFF, 8'h00};

    resetModel();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_dig_sel", 32'(dig_sel), 32'd0);
    checkOutput("reset_seg_out", 32'(seg_out), 32'd0);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);

    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      waitPos(vecs[i].drive_pos, vecs[i].accept);
      applyStimulus(vecs[i].frame, 1'b1);
      if (vecs[i].accept) exp_q.push_back('{vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3});
      step();
      applyStimulus(32'h0, 1'b0);
      checkOutput("ready_after_load", 32'(in_ready), 32'(vecs[i].ready_after));
    end

    waitPos(0, 1'b1);
    waitPos(25, 1'b0);
    checkOutput("pre_reset_dig_sel", 32'(dig_sel), 32'h4);

    rst = 1'b0;
    #1;
    checkOutput("midslot_seg_out", 32'(seg_out), 32'd0);
    checkOutput("midslot_dig_sel", 32'(dig_sel), 32'd0);
    checkOutput("midslot_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midslot_frame_start", 32'(frame_start), 32'd0);
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("held_reset_dig_sel", 32'(dig_sel), 32'd0);
    rst = 1'b1;
    repeat (FRAME + 5) step();

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slon5_scan_m.md
SLON5_SCAN_M -- requirements
Module: slon5_scan_m

Interface
REQ-001 Parameter DIGITS, default 4: number of display digits scanned; legal range 2..8.
REQ-002 Parameter SEG_W, default 8: segment bits per digit (7 segments + dp).
REQ-003 Parameter DWELL_CYCLES, default 50_000: clk cycles a digit is driven per scan slot; legal minimum 4.
REQ-004 Parameter BLANK_CYCLES, default 500: clk cycles of all-off between slots, for anti-ghosting; legal minimum 1.
REQ-005 clk  input  1  system clock; all state sampled on its rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 seg_in  input  DIGITS*SEG_W  frame of segment codes; digit k occupies bits [k*SEG_W +: SEG_W].
REQ-008 in_valid  input  1  seg_in holds a frame to load.
REQ-009 in_ready  output  1  block can accept a frame.
REQ-010 seg_out  output  SEG_W  active-high segment drive for the selected digit.
REQ-011 dig_sel  output  DIGITS  active-high, one-hot digit select; all-zero during blanking.
REQ-012 frame_start  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-013 FSM states: BLANK and ON; digit index idx ranges 0..DIGITS-1.
REQ-014 BLANK lasts exactly BLANK_CYCLES cycles, with dig_sel=0 and seg_out=0; it then transitions to ON.
REQ-015 ON lasts exactly DWELL_CYCLES cycles, with dig_sel=1<<idx and seg_out=active[idx]; it then transitions to BLANK with idx+1.
REQ-016 idx wraps from DIGITS-1 to 0; frame period is DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-017 A transfer occurs on any rising edge with in_valid=1 and in_ready=1; seg_in is captured into the pending register and in_ready goes 0 on the next cycle.
REQ-018 Frame boundary: the ON->BLANK transition where idx wraps to 0.
REQ-019 At a frame boundary with a pending frame: active<=pending, pending cleared, in_ready=1 from the next cycle.
REQ-020 At a frame boundary with no pending frame but a transfer on that same edge: active<=seg_in directly (bypass), and in_ready stays 1.
REQ-021 active is never modified except at a frame boundary, so no partial frame (tearing) is ever displayed.
REQ-022 Only one frame can be pending; while in_ready=0, in_valid is ignored.
REQ-023 frame_start=1 for exactly the first cycle of BLANK with idx=0, including the first cycle after reset release.
REQ-024 Outputs are registered; dig_sel and seg_out change on the same edge, never on different edges.
REQ-025 Counter widths are derived with clog2 from the parameters; counters never exceed their terminal count.

Reset
REQ-026 Asserting rst at any time, including mid-slot, forces within the same cycle: state=BLANK, idx=0, counters=0, active=0, pending cleared, seg_out=0, dig_sel=0, frame_start=0, in_ready=0.
REQ-027 After rst deasserts, in_ready=1 from the first rising edge, and frame_start pulses on that first cycle.

Configuration
REQ-028 Macro SLON5_SCAN_BRIGHT_EN defined: adds port bright (input, 4 bits); during ON, seg_out=active[idx] only for the first floor(DWELL_CYCLES*(bright+1)/16) cycles and 0 for the rest; dig_sel is unaffected; bright is sampled at frame_start.
REQ-029 Macro SLON5_SCAN_BRIGHT_EN undefined: no bright port; seg_out is driven for the entire ON period.

Verification (DIGITS=4, SEG_W=8, DWELL_CYCLES=8, BLANK_CYCLES=2)
REQ-030 Release reset with no input -> dig_sel sequence 0000x2, 0001x8, 0000x2, 0010x8, ... 1000x8; frame_start every 40 cycles; seg_out=0 throughout.
REQ-031 Load 0x3F06_5B4F at cycle 5 -> in_ready=0 from cycle 6; active updates at cycle 40; frame 2 shows digit0=0x4F, digit1=0x5B, digit2=0x06, digit3=0x3F.
REQ-032 in_valid held high with a new frame on the boundary edge while in_ready=1 -> bypass load; in_ready never drops; the next frame shows the new data.
REQ-033 Assert rst in the middle of digit 2 ON -> seg_out, dig_sel and in_ready all 0 immediately; the scan restarts at digit 0 BLANK with a frame_start pulse.
REQ-034 With SLON5_SCAN_BRIGHT_EN and bright=3 -> seg_out is nonzero for 2 of the 8 ON cycles per slot; with bright=15 -> nonzero for all 8.
REQ-035 Second in_valid while a frame is pending -> ignored; the displayed frame equals the first pending frame.
